// File: rtl/ibex_pkg.sv
// Shared types for the instruction fetch request sequencer.
package ibex_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    STALE = 2'd2
  } fetch_req_state_e;

endpackage

// File: rtl/ibex_fetch_req_ctrl.sv
// Fetch request sequencer: issues word-aligned bus requests, tracks outstanding
// responses in order and drops responses that belong to a stream killed by a branch.
module ibex_fetch_req_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned NUM_REQS = 2,
  parameter bit          ResetAll = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  output logic                busy_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o
);

  fetch_req_state_e    state_q, state_d;
  logic [31:0]         fetch_addr_q, fetch_addr_d, target_q, target_d, br_addr;
  logic [NUM_REQS-1:0] out_v_q, out_v_d, out_disc_q, out_disc_d, sh_v, sh_d;
  logic                push, push_disc, pop, space_ok;
  int unsigned         out_cnt, pend_cnt, fill_cnt;

  assign br_addr   = {addr_i[31:2], 2'b00};
  assign push      = instr_req_o & instr_gnt_i;
  assign push_disc = branch_i | (state_q == STALE);
  assign pop       = instr_rvalid_i & out_v_q[0];

  // A grant this cycle already counts against the budget for the next request,
  // otherwise back-to-back grants could overrun the queue by one.
  always_comb begin
    out_cnt = 0;
    for (int i = 0; i < NUM_REQS; i++) out_cnt = out_cnt + {31'd0, out_v_q[i]};
    fill_cnt = $countones(fifo_busy_i);
    pend_cnt = out_cnt + {31'd0, push};
    if (branch_i) space_ok = pend_cnt < NUM_REQS;
    else          space_ok = (fill_cnt + pend_cnt) < NUM_REQS;
  end

  // Outstanding queue, entry 0 is the oldest; pop shifts down, push fills the first free slot.
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_out
    logic nxt_v, nxt_d, push_here;
    if (i == NUM_REQS - 1) begin : g_tail
      assign nxt_v = 1'b0;
      assign nxt_d = 1'b0;
    end else begin : g_body
      assign nxt_v = out_v_q[i+1];
      assign nxt_d = out_disc_q[i+1];
    end
    assign sh_v[i] = pop ? nxt_v : out_v_q[i];
    assign sh_d[i] = (pop ? nxt_d : out_disc_q[i]) | branch_i;
    if (i == 0) begin : g_head
      assign push_here = push & ~sh_v[0];
    end else begin : g_rest
      assign push_here = push & ~sh_v[i] & sh_v[i-1];
    end
    assign out_v_d[i]    = sh_v[i] | push_here;
    assign out_disc_d[i] = push_here ? push_disc : (sh_v[i] & sh_d[i]);
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    target_d     = target_q;
    unique case (state_q)
      IDLE: begin
        if (branch_i) fetch_addr_d = br_addr;
        if (req_i && space_ok) state_d = REQ;
      end
      REQ: begin
        if (instr_gnt_i) begin
          fetch_addr_d = branch_i ? br_addr : fetch_addr_q + 32'd4;
          state_d      = (req_i && space_ok) ? REQ : IDLE;
        end else if (branch_i) begin
          target_d = br_addr;
          state_d  = STALE;
        end
      end
      STALE: begin
        if (branch_i) target_d = br_addr;
        if (instr_gnt_i) begin
          fetch_addr_d = branch_i ? br_addr : target_q;
          state_d      = (req_i && space_ok) ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      out_v_q    <= '0;
      out_disc_q <= '0;
    end else begin
      state_q    <= state_d;
      out_v_q    <= out_v_d;
      out_disc_q <= out_disc_d;
    end
  end

  if (ResetAll) begin : g_addr_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        fetch_addr_q <= '0;
        target_q     <= '0;
      end else begin
        fetch_addr_q <= fetch_addr_d;
        target_q     <= target_d;
      end
    end
  end else begin : g_addr_nrst
    always_ff @(posedge clk_i) begin
      fetch_addr_q <= fetch_addr_d;
      target_q     <= target_d;
    end
  end

  always_comb begin
    instr_req_o = (state_q != IDLE);
  end

  assign instr_addr_o = fetch_addr_q;
  assign busy_o       = instr_req_o | (|out_v_q);
  assign fifo_clear_o = branch_i;
  assign fifo_valid_o = instr_rvalid_i & ~out_disc_q[0] & ~branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;

  a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_rvalid_i |-> out_v_q[0]);
  a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (instr_req_o && !instr_gnt_i) |=> (instr_req_o && $stable(instr_addr_o)));
  a_fifo_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (&fifo_busy_i) |-> !fifo_valid_o);

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Directed scenarios plus a random phase, all checked against a stream-level model.
module tb_ibex_fetch_req_ctrl;
  localparam int N = 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req = 1'b0, branch = 1'b0, gnt = 1'b0, rvalid = 1'b0, err = 1'b0;
  logic [31:0]   addr = '0, rdata = '0;
  logic [N-1:0]  fbusy = '0;
  logic          busy_o, instr_req_o, fifo_clear_o, fifo_valid_o, fifo_err_o;
  logic [31:0]   instr_addr_o, fifo_addr_o, fifo_rdata_o;

  int npass = 0, nfail = 0, ntot = 0;

  // Model: current request (if any), its address, a pending branch target while
  // an old request is still waiting for its grant, and one drop flag per response.
  bit          m_req, m_stale;
  logic [31:0] m_addr, m_tgt;
  bit          dq[$];

  ibex_fetch_req_ctrl #(.NUM_REQS(N), .ResetAll(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .branch_i(branch), .addr_i(addr),
    .busy_o(busy_o), .instr_req_o(instr_req_o), .instr_gnt_i(gnt),
    .instr_addr_o(instr_addr_o), .instr_rvalid_i(rvalid), .instr_rdata_i(rdata),
    .instr_err_i(err), .fifo_busy_i(fbusy), .fifo_clear_o(fifo_clear_o),
    .fifo_valid_o(fifo_valid_o), .fifo_addr_o(fifo_addr_o), .fifo_rdata_o(fifo_rdata_o),
    .fifo_err_o(fifo_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_stale = 0; m_addr = '0; m_tgt = '0; dq.delete();
  endtask

  // Check outputs mid-cycle, then advance the model and the clock by one edge.
  task automatic tick();
    bit          granted, ok, exp_fv;
    int          pend, fill;
    logic [31:0] br;
    @(negedge clk);
    exp_fv = rvalid && dq.size() > 0 && !dq[0] && !branch;
    chk("req", instr_req_o, m_req);
    if (m_req) chk("addr", instr_addr_o, m_addr);
    chk("fvalid", fifo_valid_o, exp_fv);
    chk("busy", busy_o, m_req || dq.size() != 0);
    chk("clear", fifo_clear_o, branch);
    if (rvalid) chk("err", fifo_err_o, err);
    br      = {addr[31:2], 2'b00};
    granted = m_req && gnt;
    pend    = dq.size() + int'(granted);
    fill    = $countones(fbusy);
    ok      = branch ? (pend < N) : (fill + pend < N);
    if (branch) foreach (dq[i]) dq[i] = 1;
    if (rvalid && dq.size() > 0) void'(dq.pop_front());
    if (granted) dq.push_back(branch || m_stale);
    if (!m_req) begin
      if (branch) m_addr = br;
      m_req = req && ok;
    end else if (m_stale) begin
      if (branch) m_tgt = br;
      if (gnt) begin m_stale = 0; m_addr = m_tgt; m_req = req && ok; end
    end else if (gnt) begin
      m_addr = branch ? br : m_addr + 32'd4;
      m_req  = req && ok;
    end else if (branch) begin
      m_stale = 1; m_tgt = br;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", instr_req_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_fvalid", fifo_valid_o, 1'b0);
    rst_n = 1'b1;

    // 1: branch to 0x100 while enabling, first response pushed
    req = 1; branch = 1; addr = 32'h100; gnt = 1; tick();
    branch = 0; #1;
    chk("t1_a0", instr_addr_o, 32'h100);
    tick();
    gnt = 0; #1;
    chk("t1_a1", instr_addr_o, 32'h104);
    tick();
    rvalid = 1; rdata = 32'hDEAD_BEEF; #1;
    chk("t1_push", fifo_valid_o, 1'b1);
    chk("t1_rdata", fifo_rdata_o, 32'hDEAD_BEEF);
    tick();
    rvalid = 0;

    // 2: request held without grant
    for (int i = 0; i < 5; i++) begin
      #1 chk("t2_hold", instr_addr_o, 32'h104);
      tick();
    end
    gnt = 1; tick();

    // 3: two outstanding with FIFO partly full -> no further request
    fbusy = 2'b01; tick();
    gnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_stall", instr_req_o, 1'b0);
      tick();
    end
    fbusy = 2'b00; rvalid = 1; tick();
    rvalid = 0; tick();
    #1 chk("t3_resume", instr_addr_o, 32'h10C);

    // 4: branch with two outstanding drops both responses
    gnt = 1; tick();
    gnt = 0; branch = 1; addr = 32'h202; rvalid = 1; #1;
    chk("t4_faddr", fifo_addr_o, 32'h202);
    tick();
    branch = 0; tick();
    rvalid = 0; #1;
    chk("t4_target", instr_addr_o, 32'h200);
    chk("t4_req", instr_req_o, 1'b1);

    // 5: branch while the old request waits for its grant
    branch = 1; addr = 32'h10; gnt = 1; tick();
    branch = 0; gnt = 0; rvalid = 1; tick();
    rvalid = 0; branch = 1; addr = 32'h400; tick();
    branch = 0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("t5_old", instr_addr_o, 32'h10);
      tick();
    end
    gnt = 1; tick();
    gnt = 0; #1;
    chk("t5_new", instr_addr_o, 32'h400);
    rvalid = 1; tick();
    rvalid = 0;

    // 6: reset with responses outstanding
    gnt = 1; tick(); tick();
    gnt = 0; req = 0; rst_n = 0; #1;
    chk("t6_busy", busy_o, 1'b0);
    chk("t6_req", instr_req_o, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    tick();

    // Random phase
    for (int c = 0; c < 400; c++) begin
      int k;
      req    = ($urandom_range(7, 0) != 0);
      gnt    = $urandom_range(1, 0) == 1;
      branch = ($urandom_range(9, 0) == 0);
      addr   = $urandom;
      rvalid = (dq.size() > 0) && ($urandom_range(9, 0) < 4);
      rdata  = $urandom;
      err    = $urandom_range(1, 0) == 1;
      k      = $urandom_range(N - dq.size(), 0);
      fbusy  = '0;
      for (int i = 0; i < k; i++) fbusy[i] = 1'b1;
      tick();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
